// File: rtl/st_bus_master_if.sv
// Command and 68000-bus signal bundle for st_bus_master.
// master = the bus initiator; slave = command source plus bus/responder side.
interface st_bus_master_if;
  logic        CMD_REQ, CMD_RW, CMD_UDS, CMD_LDS;
  logic [22:0] CMD_A;
  logic [15:0] CMD_WDATA;
  logic        CMD_ACK, CMD_BERR;
  logic [15:0] CMD_RDATA;
  logic        BUSY;
  logic        BR_N, BG_N, BGACK_N, BGACK_IN_N, AS_IN_N;
  logic        AS_N, UDS_N, LDS_N, RW;
  logic [22:0] A_OUT;
  logic        A_OE;
  logic [15:0] D_OUT;
  logic        D_OE;
  logic [15:0] D_IN;
  logic        DTACK_N, BERR_N;

  modport master (
    input  CMD_REQ, CMD_RW, CMD_UDS, CMD_LDS, CMD_A, CMD_WDATA,
    output CMD_ACK, CMD_BERR, CMD_RDATA, BUSY,
    output BR_N, BGACK_N, AS_N, UDS_N, LDS_N, RW, A_OUT, A_OE, D_OUT, D_OE,
    input  BG_N, BGACK_IN_N, AS_IN_N, D_IN, DTACK_N, BERR_N
  );

  modport slave (
    output CMD_REQ, CMD_RW, CMD_UDS, CMD_LDS, CMD_A, CMD_WDATA,
    input  CMD_ACK, CMD_BERR, CMD_RDATA, BUSY,
    input  BR_N, BGACK_N, AS_N, UDS_N, LDS_N, RW, A_OUT, A_OE, D_OUT, D_OE,
    output BG_N, BGACK_IN_N, AS_IN_N, D_IN, DTACK_N, BERR_N
  );
endinterface

// File: rtl/st_bus_master.sv
// ST-side 68000 bus initiator: arbitrates via BR/BG/BGACK and runs one async word cycle.
// Optional ST_BUS_HOLD_EN: keep bus ownership across back-to-back commands.
module st_bus_master #(
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2,
  parameter int TIMEOUT   = 255
) (
  input logic             CLKOSC,
  input logic             RST,
  st_bus_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, REQ, OWN, ADDR, STROBE, TERM, REL} state_t;

  typedef struct packed {
    logic        rw;
    logic        uds;
    logic        lds;
    logic [22:0] a;
    logic [15:0] wdata;
  } cmd_t;

`ifdef ST_BUS_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] TO_LIMIT   = 8'(TIMEOUT);

  state_t      state, state_nxt;
  cmd_t        cmd, cmd_nxt, cmd_in;
  logic [7:0]  cnt, cnt_nxt;
  logic        err, err_nxt;
  logic [15:0] rbuf, rbuf_nxt;
  logic [4:0]  sync0, sync1;
  logic        bg_s, bgack_s, as_s, dtack_s, berr_s;
  logic        own_nxt, ds_on_nxt, last_term_nxt;

  logic        br_n_q, bgack_n_q, as_n_q, uds_n_q, lds_n_q, rw_q, a_oe_q, d_oe_q;
  logic        ack_q, berr_q, busy_q;
  logic [15:0] rdata_q;

  assign cmd_in = {bus.CMD_RW, bus.CMD_UDS, bus.CMD_LDS, bus.CMD_A, bus.CMD_WDATA};

  // Bus inputs from the asynchronous 68k side; idle level is 1
  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST) begin
      sync0 <= '1;
      sync1 <= '1;
    end else begin
      sync0 <= {bus.BG_N, bus.BGACK_IN_N, bus.AS_IN_N, bus.DTACK_N, bus.BERR_N};
      sync1 <= sync0;
    end
  end
  assign {bg_s, bgack_s, as_s, dtack_s, berr_s} = sync1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cmd_nxt   = cmd;
    err_nxt   = err;
    rbuf_nxt  = rbuf;
    case (state)
      IDLE:   if (bus.CMD_REQ) begin
                cmd_nxt   = cmd_in;
                state_nxt = REQ;
              end
      REQ:    if (!bg_s && as_s && bgack_s) state_nxt = OWN;
      OWN:    begin
                cnt_nxt   = 8'd0;
                state_nxt = ADDR;
              end
      ADDR:   if (cnt == SETUP_LAST) begin
                cnt_nxt   = 8'd0;
                state_nxt = STROBE;
              end else cnt_nxt = cnt + 8'd1;
      STROBE: begin
                cnt_nxt = cnt + 8'd1;
                // BERR beats DTACK when both land in the same sample
                if (!berr_s) begin
                  err_nxt   = 1'b1;
                  cnt_nxt   = 8'd0;
                  state_nxt = TERM;
                end else if (!dtack_s) begin
                  err_nxt   = 1'b0;
                  if (cmd.rw) rbuf_nxt = bus.D_IN;
                  cnt_nxt   = 8'd0;
                  state_nxt = TERM;
                end else if (cnt + 8'd1 == TO_LIMIT) begin
                  err_nxt   = 1'b1;
                  cnt_nxt   = 8'd0;
                  state_nxt = TERM;
                end
              end
      TERM:   if (cnt == HOLD_LAST) begin
                cnt_nxt   = 8'd0;
                state_nxt = REL;
              end else cnt_nxt = cnt + 8'd1;
      REL:    begin
                cnt_nxt = 8'd0;
                if (bus.CMD_REQ) begin
                  cmd_nxt   = cmd_in;
                  state_nxt = HOLD_EN ? OWN : REQ;
                end else state_nxt = IDLE;
              end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from next-state so strobes never glitch on decode
  always_comb begin
    own_nxt       = state_nxt inside {OWN, ADDR, STROBE, TERM};
    ds_on_nxt     = (state_nxt == STROBE) && (cmd_nxt.rw || cnt_nxt != 8'd0);
    last_term_nxt = (state_nxt == TERM) && (cnt_nxt == HOLD_LAST);
  end

  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      cmd       <= '0;
      err       <= 1'b0;
      rbuf      <= 16'h0;
      br_n_q    <= 1'b1;
      bgack_n_q <= 1'b1;
      as_n_q    <= 1'b1;
      uds_n_q   <= 1'b1;
      lds_n_q   <= 1'b1;
      rw_q      <= 1'b1;
      a_oe_q    <= 1'b0;
      d_oe_q    <= 1'b0;
      ack_q     <= 1'b0;
      berr_q    <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= 16'h0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cmd       <= cmd_nxt;
      err       <= err_nxt;
      rbuf      <= rbuf_nxt;
      br_n_q    <= state_nxt != REQ;
      // with bus hold, BGACK stays low through REL and drops only on return to IDLE
      bgack_n_q <= !(own_nxt || (HOLD_EN && state_nxt == REL));
      as_n_q    <= state_nxt != STROBE;
      uds_n_q   <= !(ds_on_nxt && cmd_nxt.uds);
      lds_n_q   <= !(ds_on_nxt && cmd_nxt.lds);
      rw_q      <= own_nxt ? cmd_nxt.rw : 1'b1;
      a_oe_q    <= own_nxt;
      d_oe_q    <= own_nxt && !cmd_nxt.rw;
      busy_q    <= state_nxt inside {REQ, OWN, ADDR, STROBE, TERM};
      ack_q     <= last_term_nxt;
      if (last_term_nxt) begin
        berr_q  <= err_nxt;
        rdata_q <= rbuf_nxt;
      end
    end
  end

  assign bus.BR_N      = br_n_q;
  assign bus.BGACK_N   = bgack_n_q;
  assign bus.AS_N      = as_n_q;
  assign bus.UDS_N     = uds_n_q;
  assign bus.LDS_N     = lds_n_q;
  assign bus.RW        = rw_q;
  assign bus.A_OUT     = cmd.a;
  assign bus.A_OE      = a_oe_q;
  assign bus.D_OUT     = cmd.wdata;
  assign bus.D_OE      = d_oe_q;
  assign bus.CMD_ACK   = ack_q;
  assign bus.CMD_BERR  = berr_q;
  assign bus.CMD_RDATA = rdata_q;
  assign bus.BUSY      = busy_q;
endmodule
